// File: rtl/show_arbiter.sv
// rtl/show_arbiter.sv - round-robin scheduler sharing one registered report port among NREQ requesters
// Owns the shared cycle counter; stops accepting at FINISH_CYC, drains pending reports, then raises done.
module show_arbiter #(
  parameter int NREQ       = 4,
  parameter int TAG_W      = 16,
  parameter int FINISH_CYC = 99,
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*TAG_W-1:0] tag_in,
  output logic [NREQ-1:0]       acc,
  output logic                  out_valid,
  output logic [IW-1:0]         out_idx,
  output logic [TAG_W-1:0]      out_tag,
  output logic [31:0]           cyc,
  output logic                  done
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [NREQ-1:0]   pend;
  logic [TAG_W-1:0]  tag_q [NREQ];
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     ptr_nxt;
  logic [IW:0]       scan;
  logic              gnt_any;
  logic [NREQ-1:0]   gnt_mask;

  // A slot is only refilled once its previous report has been granted.
  assign acc = req & ~pend & {NREQ{state == S_RUN}};

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel      = ptr;
    scan     = '0;
    gnt_mask = '0;
    gnt_any  = (|pend) && (state != S_DONE);
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (IW + 1)'(k);
      if (scan >= (IW + 1)'(NREQ)) scan = scan - (IW + 1)'(NREQ);
      if (pend[scan[IW-1:0]]) sel = scan[IW-1:0];
    end
    if (gnt_any) gnt_mask[sel] = 1'b1;
    ptr_nxt = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= S_RUN;
      pend      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_tag   <= '0;
      cyc       <= '0;
      done      <= 1'b0;
    end else begin
      pend      <= (pend & ~gnt_mask) | acc;
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_idx <= sel;
        out_tag <= tag_q[sel];
        ptr     <= ptr_nxt;
      end
      case (state)
        S_RUN: begin
          cyc <= cyc + 32'd1;
          if (cyc == 32'(FINISH_CYC)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          cyc <= cyc + 32'd1;
          if (pend == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag storage is qualified by pend, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) tag_q[i] <= tag_in[i*TAG_W +: TAG_W];
    end
  end

endmodule
